pc_fetch_unit: RTL and testbench

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

---
 rtl/pc_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_pc_fetch_unit.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_unit.sv
// Program-counter fetch unit: BOOT/RUN/HALTED sequencer with flag-conditioned
// branches, absolute jumps, register jumps and a one-cycle redirect pulse.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        halt_req,
    input  logic [3:0]  br_type,
    input  logic [1:0]  pc_sel,
    input  logic [15:0] imm16,
    input  logic [25:0] jtarget,
    input  logic [31:0] rs_data,
    input  logic        flag_we,
    input  logic [3:0]  alu_flags,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [3:0]  flags,
    output logic        instr_valid,
    output logic        redirect,
    output logic        halted
);

    typedef enum logic [1:0] {
        ST_BOOT   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        w_advance;

    logic [31:0] r_pc;
    logic [3:0]  r_flags;
    logic        r_instr_valid;
    logic        r_redirect;

    logic        w_taken;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_target;
    logic [31:0] w_next_pc;
    logic        w_unused;

    assign w_pc_plus4  = r_pc + 32'd4;
    assign w_br_target = w_pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
    assign w_unused    = ^rs_data[1:0];

    // Flag register layout is {V,S,C,Z}; conditions look at the registered copy.
    always_comb begin
        w_taken = 1'b0;
        case (br_type)
            4'h0:    w_taken = 1'b1;
            4'h1:    w_taken = r_flags[0];
            4'h2:    w_taken = ~r_flags[0];
            4'h3:    w_taken = r_flags[1];
            4'h4:    w_taken = ~r_flags[1];
            4'h5:    w_taken = r_flags[2];
            4'h6:    w_taken = ~r_flags[2];
            4'h7:    w_taken = r_flags[3];
            4'h8:    w_taken = ~r_flags[3];
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next_pc = w_taken ? w_br_target : w_pc_plus4;
        case (pc_sel)
            2'b01:   w_next_pc = {w_pc_plus4[31:28], jtarget, 2'b00};
            2'b10:   w_next_pc = {rs_data[31:2], 2'b00};
            default: w_next_pc = w_taken ? w_br_target : w_pc_plus4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Halt request outranks stall; BOOT always moves on and ignores halt_req.
    always_comb begin
        w_state_next = r_state;
        w_advance    = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (halt_req) begin
                    w_state_next = ST_HALTED;
                end else if (!stall) begin
                    w_advance = 1'b1;
                end
            end
            ST_HALTED: begin
                w_state_next = ST_HALTED;
            end
            default: begin
                w_state_next = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_flags       <= 4'b0000;
            r_instr_valid <= 1'b0;
            r_redirect    <= 1'b0;
        end else begin
            r_redirect <= 1'b0;
            case (r_state)
                ST_BOOT: begin
                    r_instr_valid <= 1'b1;
                end
                ST_RUN: begin
                    if (halt_req) begin
                        r_instr_valid <= 1'b0;
                    end else if (w_advance) begin
                        r_pc       <= w_next_pc;
                        r_redirect <= (w_next_pc != w_pc_plus4);
                        if (flag_we) begin
                            r_flags <= alu_flags;
                        end
                    end
                end
                default: begin
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign flags       = r_flags;
    assign instr_valid = r_instr_valid;
    assign redirect    = r_redirect;
    assign halted      = (r_state == ST_HALTED);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus a randomized run, all
// checked against a cycle-level behavioural model of the fetch rules.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        halt_req;
    logic [3:0]  br_type;
    logic [1:0]  pc_sel;
    logic [15:0] imm16;
    logic [25:0] jtarget;
    logic [31:0] rs_data;
    logic        flag_we;
    logic [3:0]  alu_flags;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [3:0]  flags;
    logic        instr_valid;
    logic        redirect;
    logic        halted;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: 0 = BOOT, 1 = RUN, 2 = HALTED
    int          m_state;
    logic [31:0] m_pc;
    logic [3:0]  m_flags;
    logic        m_valid;
    logic        m_redir;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .halt_req    (halt_req),
        .br_type     (br_type),
        .pc_sel      (pc_sel),
        .imm16       (imm16),
        .jtarget     (jtarget),
        .rs_data     (rs_data),
        .flag_we     (flag_we),
        .alu_flags   (alu_flags),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .flags       (flags),
        .instr_valid (instr_valid),
        .redirect    (redirect),
        .halted      (halted)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    function automatic bit cond_holds(input logic [3:0] code, input logic [3:0] f);
        bit z = f[0];
        bit c = f[1];
        bit s = f[2];
        bit v = f[3];
        case (code)
            4'd0: return 1;
            4'd1: return z;
            4'd2: return !z;
            4'd3: return c;
            4'd4: return !c;
            4'd5: return s;
            4'd6: return !s;
            4'd7: return v;
            4'd8: return !v;
            default: return 0;
        endcase
    endfunction

    task automatic model_update();
        logic [31:0] seq;
        logic [31:0] tgt;
        int          off;
        if (rst) begin
            m_state = 0; m_pc = 32'h0; m_flags = 4'h0; m_valid = 0; m_redir = 0;
        end else if (m_state == 0) begin
            m_state = 1; m_valid = 1; m_redir = 0;
        end else if (m_state == 1) begin
            if (halt_req) begin
                m_state = 2; m_valid = 0; m_redir = 0;
            end else if (stall) begin
                m_redir = 0;
            end else begin
                seq = m_pc + 32'd4;
                off = int'($signed(imm16));
                if (pc_sel == 2'd1)
                    tgt = {seq[31:28], 28'h0} + {4'h0, jtarget, 2'b00};
                else if (pc_sel == 2'd2)
                    tgt = rs_data & 32'hFFFF_FFFC;
                else if (cond_holds(br_type, m_flags))
                    tgt = seq + 32'(off * 4);
                else
                    tgt = seq;
                m_redir = (tgt != seq);
                m_pc = tgt;
                if (flag_we) m_flags = alu_flags;
            end
        end else begin
            m_valid = 0; m_redir = 0;
        end
    endtask

    // One clock: model advances with the current inputs, DUT sampled 1 after the edge.
    task automatic step(input string what);
        model_update();
        @(posedge clk);
        #1;
        check_value({what, ":pc"},       pc,          m_pc);
        check_value({what, ":pc_plus4"}, pc_plus4,    m_pc + 32'd4);
        check_value({what, ":flags"},    {28'h0, flags},  {28'h0, m_flags});
        check_value({what, ":valid"},    {31'h0, instr_valid}, {31'h0, m_valid});
        check_value({what, ":redirect"}, {31'h0, redirect},    {31'h0, m_redir});
        check_value({what, ":halted"},   {31'h0, halted},      {31'h0, (m_state == 2)});
        $display("%-10s rst=%0d stl=%0d hlt=%0d sel=%0d br=%0h pc=%08h flg=%0h v=%0d rd=%0d h=%0d",
                 what, rst, stall, halt_req, pc_sel, br_type, pc, flags, instr_valid, redirect, halted);
    endtask

    task automatic idle_inputs();
        rst = 0; stall = 0; halt_req = 0; br_type = 4'h9; pc_sel = 2'd0;
        imm16 = 16'h0; jtarget = 26'h0; rs_data = 32'h0; flag_we = 0; alu_flags = 4'h0;
    endtask

    task automatic jump_reg(input logic [31:0] addr);
        idle_inputs(); pc_sel = 2'd2; rs_data = addr;
        step("jr");
    endtask

    logic [31:0] exp_seq [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    logic [31:0] saved_pc;

    initial begin
        idle_inputs();
        rst = 1;
        #2;
        step("reset");
        step("reset");
        check_value("reset_pc", pc, 32'h0);
        check_value("reset_valid", {31'h0, instr_valid}, 32'h0);

        // Sequential fetch out of reset; halt_req during BOOT must be ignored.
        idle_inputs();
        halt_req = 1;
        step("boot");
        check_value("boot_pc", pc, 32'h0);
        check_value("boot_nohalt", {31'h0, halted}, 32'h0);
        idle_inputs();
        for (int i = 1; i < 4; i++) begin
            step("seq");
            check_value("seq_pc", pc, exp_seq[i]);
        end

        // Taken BZ backwards, using flags loaded the cycle before.
        jump_reg(32'h0000_001C);
        idle_inputs(); flag_we = 1; alu_flags = 4'b0001;
        step("setflag");
        check_value("at_0x20", pc, 32'h20);
        idle_inputs(); br_type = 4'h1; imm16 = 16'hFFFE;
        step("bz");
        check_value("bz_pc", pc, 32'h1C);
        check_value("bz_redir", {31'h0, redirect}, 32'h1);
        idle_inputs();
        step("after_bz");
        check_value("redir_pulse", {31'h0, redirect}, 32'h0);
        jump_reg(32'h0000_001C);
        idle_inputs(); flag_we = 1; alu_flags = 4'b0001;
        step("setflag");
        idle_inputs(); br_type = 4'h2; imm16 = 16'hFFFE;
        step("bnz");
        check_value("bnz_pc", pc, 32'h24);
        check_value("bnz_redir", {31'h0, redirect}, 32'h0);

        // Absolute and register jumps.
        jump_reg(32'h3000_0010);
        idle_inputs(); pc_sel = 2'd1; jtarget = 26'h0000100;
        step("j");
        check_value("j_pc", pc, 32'h3000_0400);
        idle_inputs(); pc_sel = 2'd2; rs_data = 32'h0000_1237;
        step("jr");
        check_value("jr_pc", pc, 32'h0000_1234);

        // Stall holds pc and flags across a pending taken branch and flag write.
        idle_inputs(); flag_we = 1; alu_flags = 4'b0001;
        step("setflag");
        saved_pc = pc;
        for (int i = 0; i < 3; i++) begin
            idle_inputs(); stall = 1; br_type = 4'h1; imm16 = 16'h0010;
            flag_we = 1; alu_flags = 4'b0000;
            step("stall");
            check_value("stall_pc", pc, saved_pc);
            check_value("stall_flags", {28'h0, flags}, 32'h1);
            check_value("stall_redir", {31'h0, redirect}, 32'h0);
        end
        stall = 0;
        step("release");
        check_value("release_pc", pc, saved_pc + 32'd4 + 32'h40);
        check_value("release_redir", {31'h0, redirect}, 32'h1);

        // Wrap-around is a plain sequential step.
        jump_reg(32'hFFFF_FFFC);
        idle_inputs();
        step("wrap");
        check_value("wrap_pc", pc, 32'h0);
        check_value("wrap_redir", {31'h0, redirect}, 32'h0);

        // Halt beats stall and a jump, then only reset gets out.
        jump_reg(32'h0000_0100);
        idle_inputs(); halt_req = 1; stall = 1; pc_sel = 2'd1; jtarget = 26'h3FF_FFFF;
        step("halt");
        check_value("halt_flag", {31'h0, halted}, 32'h1);
        check_value("halt_valid", {31'h0, instr_valid}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            halt_req = 1'($urandom); pc_sel = 2'($urandom); rs_data = $urandom;
            flag_we = 1; alu_flags = 4'($urandom);
            step("halted");
            check_value("halt_frozen", pc, 32'h100);
        end
        idle_inputs(); rst = 1;
        step("rst_halt");
        check_value("rst_halt_pc", pc, 32'h0);
        check_value("rst_halt_h", {31'h0, halted}, 32'h0);

        // Randomized run, reset and halt requested occasionally.
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 39) == 0);
            stall     = ($urandom_range(0, 3) == 0);
            halt_req  = ($urandom_range(0, 59) == 0);
            br_type   = 4'($urandom);
            pc_sel    = 2'($urandom);
            imm16     = 16'($urandom);
            jtarget   = 26'($urandom);
            rs_data   = $urandom;
            flag_we   = 1'($urandom);
            alu_flags = 4'($urandom);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
